word_tx_serializer: RTL and testbench

Buffers 32-bit words produced by the debug unit (register file and data-memory dumps) and streams them byte by byte into `tx_uart`, handshaking on `tx_start`/`tx_done_tick`. It sits directly upstream of `tx_uart`, replacing the external `din`/`empty` drive of the transmitter. It has a small synchronous FIFO so the debug unit can post words back-to-back without waiting on the UART.

---
 rtl/word_tx_pkg.sv | 16 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/word_tx_serializer.sv | 136 +++++++++++++
 tb/tb_word_tx_serializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/word_tx_pkg.sv
// word_tx_pkg: shared types and constants for the word TX serializer.
//   state_e    : serializer FSM states (CHK only when WORD_TX_CHECKSUM_EN is defined)
//   N_BYTES    : default bytes per word
//   BYTE_IDX_W : width of the byte index within a word
package word_tx_pkg;

  localparam int N_BYTES    = 4;
  localparam int BYTE_IDX_W = $clog2(N_BYTES);

`ifdef WORD_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, START, WAIT, CHK} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request; refused while full
//   pop/rdata  : read request; rdata shows the head word combinationally
//   flush      : synchronous clear, overrides push and pop
//   count      : occupancy (0..DEPTH), full, empty
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push_ok, pop_ok;

  // Full/empty come from the pre-edge count, so a push at full is refused
  // even when a pop frees a slot on the same edge.
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers guard every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/word_tx_serializer.sv
// word_tx_serializer: queues 32-bit debug words and streams them LSB byte
// first into tx_uart using a tx_start / tx_done_tick handshake.
//   clock_i, reset_i         : clock, asynchronous active-low reset
//   wr_en_i, data_i          : word push (dropped when full, sets overflow_o)
//   flush_i                  : clear queue, abort current word
//   tx_done_tick_i           : byte-finished pulse from tx_uart
//   full_o, count_o          : queue status (word in flight not counted)
//   overflow_o               : sticky push-while-full flag
//   tx_start_o, tx_data_o    : start pulse and byte to tx_uart
//   busy_o                   : word (or checksum) in progress
// Config: define WORD_TX_CHECKSUM_EN to append an XOR checksum byte per word.
module word_tx_serializer
  import word_tx_pkg::*;
#(
  parameter int NB_DATA         = 32,
  parameter int N_BITS          = 8,
  parameter int N_BYTES         = word_tx_pkg::N_BYTES,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [NB_DATA-1:0]       data_i,
  input  logic                     flush_i,
  input  logic                     tx_done_tick_i,
  output logic                     full_o,
  output logic [FIFO_DEPTH_LOG2:0] count_o,
  output logic                     overflow_o,
  output logic                     tx_start_o,
  output logic [N_BITS-1:0]        tx_data_o,
  output logic                     busy_o
);

  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(N_BYTES - 1);

  state_e              state;
  logic [NB_DATA-1:0]  sh;
  logic [BW-1:0]       byte_idx;
  logic [NB_DATA-1:0]  fifo_rdata;
  logic                fifo_empty;
  logic                pop;

  assign pop = (state == IDLE) && !fifo_empty && !flush_i;

  sync_fifo #(
    .WIDTH      (NB_DATA),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_i),
    .push  (wr_en_i),
    .wdata (data_i),
    .pop   (pop),
    .flush (flush_i),
    .rdata (fifo_rdata),
    .count (count_o),
    .full  (full_o),
    .empty (fifo_empty)
  );

  // The byte on the wire is always the low byte of the shift register, so
  // it holds through WAIT and drops to zero the instant reset asserts.
  assign tx_data_o = sh[N_BITS-1:0];
  assign busy_o    = (state != IDLE);

`ifdef WORD_TX_CHECKSUM_EN
  logic [N_BITS-1:0] word_xor, chk;

  always_comb begin
    word_xor = '0;
    for (int i = 0; i < N_BYTES; i++) word_xor ^= fifo_rdata[i*N_BITS +: N_BITS];
  end
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      sh         <= '0;
      byte_idx   <= '0;
      tx_start_o <= 1'b0;
      overflow_o <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
      chk        <= '0;
`endif
    end else if (flush_i) begin
      // A byte already handed to tx_uart still finishes there; its tick
      // lands in IDLE and is ignored.
      state      <= IDLE;
      byte_idx   <= '0;
      tx_start_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      if (wr_en_i && full_o) overflow_o <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sh         <= fifo_rdata;
            byte_idx   <= '0;
            tx_start_o <= 1'b1;
            state      <= START;
`ifdef WORD_TX_CHECKSUM_EN
            chk        <= word_xor;
`endif
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (tx_done_tick_i) begin
            if (byte_idx == LAST_IDX) begin
`ifdef WORD_TX_CHECKSUM_EN
              sh         <= NB_DATA'(chk);
              tx_start_o <= 1'b1;
              state      <= CHK;
`else
              state      <= IDLE;
`endif
            end else begin
              sh         <= sh >> N_BITS;
              byte_idx   <= byte_idx + 1'b1;
              tx_start_o <= 1'b1;
              state      <= START;
            end
          end
        end
`ifdef WORD_TX_CHECKSUM_EN
        // First CHK cycle carries the start pulse; then wait for its tick.
        CHK: if (tx_done_tick_i && !tx_start_o) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_tx_serializer.sv
module tb_word_tx_serializer;

`ifdef WORD_TX_CHECKSUM_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic        clock_i, reset_i, wr_en_i, flush_i, tx_done_tick_i;
  logic [31:0] data_i;
  logic        full_o, overflow_o, tx_start_o, busy_o;
  logic [3:0]  count_o;
  logic [7:0]  tx_data_o;

  word_tx_serializer dut (
    .clock_i(clock_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .data_i(data_i),
    .flush_i(flush_i), .tx_done_tick_i(tx_done_tick_i), .full_o(full_o),
    .count_o(count_o), .overflow_o(overflow_o), .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o), .busy_o(busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words plus the frame being sent.
  logic [31:0] mq[$];
  logic [7:0]  frame[5];
  int          m_idx;
  bit          m_busy, m_start, m_ovf;

  // Responder: answers each observed start with a tick 'lat' cycles later.
  int          tick_cnt;
  int          lat;
  bit          resp_en;
  logic [7:0]  cap[$];

  typedef struct {
    logic [31:0] word;
    logic [31:0] seq;   // expected bytes in send order, first in [31:24]
    logic [7:0]  chk;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx = 0; m_busy = 0; m_start = 0; m_ovf = 0;
    tick_cnt = 0;
  endtask

  task automatic cycle(input bit wr, input logic [31:0] d, input bit fl);
    bit tick, full_pre, do_pop, do_push, tick_eff;
    logic [31:0] w;
    tick = 0;
    if (resp_en && tick_cnt == 1) begin tick = 1; tick_cnt = 0; end
    else if (tick_cnt > 1) tick_cnt--;
    wr_en_i = wr; data_i = d; flush_i = fl; tx_done_tick_i = tick;
    @(posedge clock_i);
    full_pre = (mq.size() == 8);
    do_pop   = !m_busy && (mq.size() != 0);
    do_push  = wr && !full_pre;
    tick_eff = tick && m_busy && !m_start;
    if (fl) begin
      mq.delete(); m_busy = 0; m_start = 0; m_ovf = 0; m_idx = 0;
    end else begin
      m_start = 0;
      if (do_pop) begin
        w = mq.pop_front();
        frame[4] = 8'h00;
        for (int i = 0; i < 4; i++) begin
          frame[i] = 8'((w >> (8 * i)) & 32'hFF);
          frame[4] = frame[4] ^ frame[i];
        end
        m_idx = 0; m_busy = 1; m_start = 1;
      end
      if (tick_eff) begin
        m_idx++;
        if (m_idx == FRAME) m_busy = 0;
        else m_start = 1;
      end
      if (do_push) mq.push_back(d);
      if (wr && full_pre) m_ovf = 1;
    end
    #1;
    wr_en_i = 0; flush_i = 0; tx_done_tick_i = 0;
    check("count", 32'(count_o), 32'(mq.size()));
    check("full", 32'(full_o), 32'(mq.size() == 8));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("busy", 32'(busy_o), 32'(m_busy));
    check("start", 32'(tx_start_o), 32'(m_start));
    if (m_start) check("byte", 32'(tx_data_o), 32'(frame[m_idx]));
    if (tx_start_o === 1'b1) begin
      cap.push_back(tx_data_o);
      tick_cnt = lat;
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((m_busy || mq.size() != 0 || tick_cnt != 0) && n < budget) begin
      cycle(0, 32'h0, 0);
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: still busy after %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h11223344, 32'h44332211, 8'h44};
    vecs[1] = '{32'hA5F00F5A, 32'h5A0FF0A5, 8'h00};
    vecs[2] = '{32'h00000000, 32'h00000000, 8'h00};
    vecs[3] = '{32'hDEADBEEF, 32'hEFBEADDE, 8'h22};

    reset_i = 0; wr_en_i = 0; flush_i = 0; tx_done_tick_i = 0; data_i = '0;
    resp_en = 1; lat = 10;
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    check("rst_start", 32'(tx_start_o), 0);
    check("rst_data", 32'(tx_data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    @(negedge clock_i);
    reset_i = 1;

    // Single words, each start answered 10 cycles later.
    for (int v = 0; v < 4; v++) begin
      cap.delete();
      lat = 10;
      cycle(1, vecs[v].word, 0);
      check("lat_edge_k", 32'(tx_start_o), 0);
      cycle(0, 32'h0, 0);
      check("lat_edge_k1", 32'(tx_start_o), 1);
      wait_idle(300, "single_word");
      check("frame_len", 32'(cap.size()), FRAME);
      for (int i = 0; i < 4; i++)
        if (cap.size() > i) check("frame_byte", 32'(cap[i]), 32'(vecs[v].seq[31 - 8*i -: 8]));
`ifdef WORD_TX_CHECKSUM_EN
      if (cap.size() > 4) check("frame_chk", 32'(cap[4]), 32'(vecs[v].chk));
`endif
      check("idle_after", 32'(busy_o), 0);
    end

    // Overflow: 10 back-to-back pushes with the UART stalled.
    cap.delete();
    resp_en = 0;
    for (int i = 0; i < 10; i++) cycle(1, 32'h5000_0000 + 32'(i) * 32'h0101_0101, 0);
    check("ovf_count", 32'(count_o), 8);
    check("ovf_full", 32'(full_o), 1);
    check("ovf_flag", 32'(overflow_o), 1);
    check("ovf_busy", 32'(busy_o), 1);

    // Push while full on the edge where the queue pops: refused, 8 -> 7.
    resp_en = 1;
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 100 && !hit; n++) begin
        bit was_full;
        was_full = (mq.size() == 8);
        cycle(1, 32'hBAD0_0000 + 32'(n), 0);
        if (was_full && mq.size() == 7) hit = 1;
      end
      check("push_at_full_seen", 32'(hit), 1);
      check("push_at_full_cnt", 32'(count_o), 7);
    end
    wait_idle(1000, "overflow_drain");
    check("ovf_words_sent", 32'(cap.size()), 9 * FRAME);

    // Flush after byte 2's tick; overflow is still set from above.
    lat = 10;
    cycle(1, 32'hCAFEF00D, 0);
    for (int n = 0; n < 100 && !(m_idx == 2 && m_start); n++) cycle(0, 32'h0, 0);
    check("pre_flush_ovf", 32'(overflow_o), 1);
    cycle(0, 32'h0, 1);
    check("flush_busy", 32'(busy_o), 0);
    check("flush_count", 32'(count_o), 0);
    check("flush_ovf", 32'(overflow_o), 0);
    repeat (15) cycle(0, 32'h0, 0);   // stray tick arrives in IDLE
    check("stray_tick_idle", 32'(busy_o), 0);
    cap.delete();
    cycle(1, 32'h01020304, 0);
    wait_idle(300, "post_flush");
    check("post_flush_len", 32'(cap.size()), FRAME);
    if (cap.size() > 0) check("post_flush_b0", 32'(cap[0]), 32'h04);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      lat = int'($urandom_range(2, 6));
      cycle($urandom_range(0, 5) == 0, $urandom, 0);
    end
    wait_idle(3000, "random_drain");

    // Asynchronous reset during WAIT.
    lat = 10;
    cycle(1, 32'h11223344, 0);
    cycle(1, 32'h55667788, 0);
    repeat (3) cycle(0, 32'h0, 0);
    check("pre_rst_busy", 32'(busy_o), 1);
    #2 reset_i = 0;
    #1;
    check("arst_start", 32'(tx_start_o), 0);
    check("arst_data", 32'(tx_data_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_count", 32'(count_o), 0);
    check("arst_full", 32'(full_o), 0);
    check("arst_ovf", 32'(overflow_o), 0);
    model_reset();
    #1 reset_i = 1;
    repeat (5) cycle(0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
